jt12_kon_wr: RTL and testbench

Key-on command front end for the FM core. Decodes CPU writes to the YM2612 key-on register (0x28, bank 0), queues them in a small FIFO, and presents each command as `keyon_ch`/`keyon_op` with `up_keyon` held for one full 24-slot sequencer round. This guarantees that the per-slot key-on shift register sees every operator of the addressed channel. The block sits between the register interface and the slot key-on storage, which samples `keyon_ch==cur_ch && up_keyon` once per slot.

---
 rtl/jt12_kon_wr_if.sv | 10 +
 rtl/jt12_kon_wr.sv | 122 ++++++++++++
 tb/tb_jt12_kon_wr.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/jt12_kon_wr_if.sv
// CPU register write bus feeding the key-on command front end.
interface jt12_kon_wr_if;
    logic       wr_en;
    logic       wr_bank;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;

    modport master (output wr_en, wr_bank, wr_addr, wr_data);
    modport slave  (input  wr_en, wr_bank, wr_addr, wr_data);
endinterface

// File: rtl/jt12_kon_wr.sv
// Key-on command front end: decodes reg 0x28 writes, queues them, and holds
// each command for one full 24-slot sequencer round.
module jt12_kon_wr #(
    parameter int unsigned DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cen,
    jt12_kon_wr_if.slave       wr,
    output logic [3:0]         keyon_op,
    output logic [2:0]         keyon_ch,
    output logic               up_keyon,
    output logic               busy,
    output logic               ovf
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    typedef struct packed {
        logic [3:0] op;
        logic [2:0] ch;
    } kon_entry_t;

    typedef enum logic {IDLE, HOLD} state_t;

    state_t     state, state_nxt;
    kon_entry_t mem [DEPTH];
    logic [PW-1:0] wp, rp;
    logic [4:0]    cnt, cnt_nxt;
    logic [3:0]    op_nxt;
    logic [2:0]    ch_nxt;
    logic          up_nxt, busy_nxt;
    logic          accept_c, empty_c, full_c, push_c, drop_c, pop_c, round_end_c;
    kon_entry_t    head_c;
    logic          unused_c;

    // Data bit 3 has no meaning in the key-on register.
    assign unused_c = wr.wr_data[3];

    assign accept_c = wr.wr_en && !wr.wr_bank && (wr.wr_addr == 8'h28) &&
                      (wr.wr_data[1:0] != 2'b11);
    assign empty_c  = (wp == rp);
    assign full_c   = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    // A pop in the same cycle frees the slot the write lands in.
    assign push_c   = accept_c && (!full_c || pop_c);
    assign drop_c   = accept_c && full_c && !pop_c;
    assign head_c   = mem[rp[AW-1:0]];
    assign round_end_c = cen && (cnt == 5'd23);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pop_c     = 1'b0;
        case (state)
            IDLE: begin
                if (!empty_c) begin
                    pop_c     = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (round_end_c) begin
                    if (!empty_c) pop_c     = 1'b1;
                    else          state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs and slot counter.
    always_comb begin
        op_nxt  = keyon_op;
        ch_nxt  = keyon_ch;
        up_nxt  = up_keyon;
        cnt_nxt = cnt;
        if (pop_c) begin
            op_nxt  = head_c.op;
            ch_nxt  = head_c.ch;
            up_nxt  = 1'b1;
            cnt_nxt = 5'd0;
        end else if (state == HOLD && cen) begin
            if (round_end_c) begin
                up_nxt  = 1'b0;
                cnt_nxt = 5'd0;
            end else begin
                cnt_nxt = 5'(cnt + 5'd1);
            end
        end
        busy_nxt = (state_nxt == HOLD) || !empty_c;
    end

    always_ff @(posedge clk) begin
        if (push_c) mem[wp[AW-1:0]] <= kon_entry_t'({wr.wr_data[7:4], wr.wr_data[2:0]});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp       <= '0;
            rp       <= '0;
            cnt      <= '0;
            keyon_op <= '0;
            keyon_ch <= '0;
            up_keyon <= 1'b0;
            busy     <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            if (push_c) wp <= PW'(wp + PW'(1));
            if (pop_c)  rp <= PW'(rp + PW'(1));
            cnt      <= cnt_nxt;
            keyon_op <= op_nxt;
            keyon_ch <= ch_nxt;
            up_keyon <= up_nxt;
            busy     <= busy_nxt;
            if (drop_c) ovf <= 1'b1;
        end
    end
endmodule

// File: tb/tb_jt12_kon_wr.sv
// Directed bench for jt12_kon_wr: decode, round length, queueing, overflow,
// cen gating and asynchronous reset.
module tb_jt12_kon_wr;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       cen = 1'b1;
    logic [3:0] keyon_op;
    logic [2:0] keyon_ch;
    logic       up_keyon, busy, ovf;

    int errors = 0;
    int checks = 0;

    int nruns;
    int run_len [8];
    logic [2:0] run_ch [8];
    logic [3:0] run_op [8];

    jt12_kon_wr_if bus ();

    jt12_kon_wr #(.DEPTH(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cen      (cen),
        .wr       (bus),
        .keyon_op (keyon_op),
        .keyon_ch (keyon_ch),
        .up_keyon (up_keyon),
        .busy     (busy),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_wr(input logic en, input logic bank, input logic [7:0] addr,
                          input logic [7:0] data);
        bus.wr_en   = en;
        bus.wr_bank = bank;
        bus.wr_addr = addr;
        bus.wr_data = data;
    endtask

    // Records each distinct command shown while up_keyon is high and its length.
    task automatic collect();
        int t;
        t = 0;
        nruns = 0;
        while (!up_keyon && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("round_start", 32'(up_keyon), 32'd1);
        t = 0;
        while (up_keyon && t < 1000) begin
            if (nruns == 0 || keyon_ch != run_ch[nruns-1] || keyon_op != run_op[nruns-1]) begin
                if (nruns < 8) begin
                    run_ch[nruns]  = keyon_ch;
                    run_op[nruns]  = keyon_op;
                    run_len[nruns] = 0;
                    nruns++;
                end
            end
            run_len[nruns-1]++;
            @(negedge clk);
            t++;
        end
    endtask

    task automatic burst(input int n, input logic [7:0] d0, input logic [7:0] d1,
                         input logic [7:0] d2, input logic [7:0] d3,
                         input logic [7:0] d4, input logic [7:0] d5);
        logic [7:0] d [6];
        d = '{d0, d1, d2, d3, d4, d5};
        for (int i = 0; i < n; i++) begin
            set_wr(1'b1, 1'b0, 8'h28, d[i]);
            @(negedge clk);
        end
        set_wr(1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    initial begin
        logic [7:0] bad_addr [4];
        logic [7:0] bad_data [4];
        logic       bad_bank [4];
        logic [7:0] bd [5];
        int n, bm;

        set_wr(1'b0, 1'b0, 8'h00, 8'h00);
        #1 rst_n = 1'b0;
        #2;
        chk("rst_up",   32'(up_keyon), 32'd0);
        chk("rst_busy", 32'(busy),     32'd0);
        chk("rst_ovf",  32'(ovf),      32'd0);
        chk("rst_ch",   32'(keyon_ch), 32'd0);
        chk("rst_op",   32'(keyon_op), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single write 0xF1.
        set_wr(1'b1, 1'b0, 8'h28, 8'hF1);
        @(negedge clk);
        set_wr(1'b0, 1'b0, 8'h00, 8'h00);
        chk("single_up_early",   32'(up_keyon), 32'd0);
        chk("single_busy_early", 32'(busy),     32'd0);
        @(negedge clk);
        chk("single_up",   32'(up_keyon), 32'd1);
        chk("single_ch",   32'(keyon_ch), 32'd1);
        chk("single_op",   32'(keyon_op), 32'hF);
        chk("single_busy", 32'(busy),     32'd1);
        n = 0;
        bm = 0;
        while (up_keyon && n < 200) begin
            if (busy !== up_keyon) bm++;
            @(negedge clk);
            n++;
        end
        chk("single_len",        32'(n),        32'd24);
        chk("single_busy_track", 32'(bm),       32'd0);
        chk("single_busy_end",   32'(busy),     32'd0);
        chk("single_ch_kept",    32'(keyon_ch), 32'd1);
        chk("single_op_kept",    32'(keyon_op), 32'hF);
        @(negedge clk);

        // Writes that must not decode.
        bad_addr = '{8'h28, 8'h28, 8'h28, 8'h27};
        bad_data = '{8'h13, 8'h17, 8'hF1, 8'hF1};
        bad_bank = '{1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            set_wr(1'b1, bad_bank[i], bad_addr[i], bad_data[i]);
            @(negedge clk);
            set_wr(1'b0, 1'b0, 8'h00, 8'h00);
            repeat (3) @(negedge clk);
            chk($sformatf("bad%0d_up", i),   32'(up_keyon), 32'd0);
            chk($sformatf("bad%0d_busy", i), 32'(busy),     32'd0);
        end
        chk("bad_ovf", 32'(ovf), 32'd0);

        // Five queued writes: back-to-back rounds, no overflow.
        bd = '{8'h10, 8'h21, 8'h42, 8'h84, 8'h35};
        fork
            burst(5, bd[0], bd[1], bd[2], bd[3], bd[4], 8'h00);
            collect();
        join
        chk("burst_runs", 32'(nruns), 32'd5);
        for (int i = 0; i < 5 && i < nruns; i++) begin
            chk($sformatf("burst%0d_ch", i),  32'(run_ch[i]),  32'(bd[i][2:0]));
            chk($sformatf("burst%0d_op", i),  32'(run_op[i]),  32'(bd[i][7:4]));
            chk($sformatf("burst%0d_len", i), 32'(run_len[i]), 32'd24);
        end
        chk("burst_ovf",  32'(ovf),  32'd0);
        chk("burst_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);

        // Six writes: the sixth is dropped.
        fork
            burst(6, 8'h10, 8'h21, 8'h42, 8'h84, 8'h35, 8'hF6);
            collect();
        join
        chk("ovf_runs", 32'(nruns), 32'd5);
        chk("ovf_last_ch", 32'(run_ch[nruns > 0 ? nruns-1 : 0]), 32'd5);
        chk("ovf_set", 32'(ovf), 32'd1);
        repeat (5) @(negedge clk);
        chk("ovf_sticky", 32'(ovf), 32'd1);
        chk("ovf_busy",   32'(busy), 32'd0);

        // cen high every third clock during the round.
        fork
            begin
                cen = 1'b0;
                set_wr(1'b1, 1'b0, 8'h28, 8'h52);
                @(negedge clk);
                set_wr(1'b0, 1'b0, 8'h00, 8'h00);
                cen = 1'b1;
                for (int k = 0; k < 80; k++) begin
                    @(negedge clk);
                    cen = (k % 3 == 2);
                end
                cen = 1'b1;
            end
            collect();
        join
        chk("cen_runs", 32'(nruns),      32'd1);
        chk("cen_len",  32'(run_len[0]), 32'd72);
        chk("cen_ch",   32'(run_ch[0]),  32'd2);
        chk("cen_op",   32'(run_op[0]),  32'd5);
        repeat (2) @(negedge clk);

        // Reset at slot 10 with two entries queued.
        burst(3, 8'hF4, 8'h16, 8'h20, 8'h00, 8'h00, 8'h00);
        repeat (9) @(negedge clk);
        chk("mid_up", 32'(up_keyon), 32'd1);
        chk("mid_ch", 32'(keyon_ch), 32'd4);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_up",   32'(up_keyon), 32'd0);
        chk("arst_busy", 32'(busy),     32'd0);
        chk("arst_ovf",  32'(ovf),      32'd0);
        chk("arst_ch",   32'(keyon_ch), 32'd0);
        chk("arst_op",   32'(keyon_op), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        bm = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (up_keyon) n++;
            if (busy) bm++;
        end
        chk("flush_up_cycles",   32'(n),  32'd0);
        chk("flush_busy_cycles", 32'(bm), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
